// File: rtl/half_word_assembler.sv
// Half-word to 32-bit word assembler.
// Collects 16-bit beats (low half first, then high half) into a registered 32-bit output word
// with a valid/ready handshake on both sides. A low beat marked last completes a word on its own
// with a zero high half. word_cnt counts completed output handshakes and wraps silently.
// Optional feature: define HALF_MATCH_FLAG_EN to add dout_match, a registered per-half flag that
// is set when the corresponding half of the output word equals 16'h0001.
module half_word_assembler #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          din_data,
  input  logic                 din_last,
  input  logic                 din_vld,
  output logic                 din_rd,
  output logic [31:0]          dout_data,
  output logic                 dout_vld,
  input  logic                 dout_rd,
`ifdef HALF_MATCH_FLAG_EN
  output logic [1:0]           dout_match,
`endif
  output logic [CNT_WIDTH-1:0] word_cnt
);

  logic [15:0]          lo_q, lo_d;
  logic                 lo_vld_q, lo_vld_d;
  logic [31:0]          data_q, data_d;
  logic                 vld_q, vld_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef HALF_MATCH_FLAG_EN
  logic [1:0]           match_q, match_d;
`endif

  logic out_free;
  logic beat_acc;
  logic beat_complete;
  logic beat_store_lo;
  logic out_hs;

  // Handshake decode; a completing beat is only ever accepted while the output slot is free.
  always_comb begin
    out_free      = ~vld_q | dout_rd;
    din_rd        = out_free | (~lo_vld_q & ~din_last);
    beat_acc      = din_vld & din_rd;
    beat_complete = beat_acc & (lo_vld_q | din_last);
    beat_store_lo = beat_acc & ~lo_vld_q & ~din_last;
    out_hs        = vld_q & dout_rd;
  end

  // Next-state for the low-half holder, the output word and the handshake counter.
  always_comb begin
    lo_d     = lo_q;
    lo_vld_d = lo_vld_q;
    data_d   = data_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
`ifdef HALF_MATCH_FLAG_EN
    match_d  = match_q;
`endif

    if (out_hs) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      vld_d = 1'b0;
    end

    if (beat_store_lo) begin
      lo_d     = din_data;
      lo_vld_d = 1'b1;
    end

    // A new word overrides the clear from a same-cycle handshake, so there is no bubble.
    if (beat_complete) begin
      data_d   = lo_vld_q ? {din_data, lo_q} : {16'h0000, din_data};
      vld_d    = 1'b1;
      lo_vld_d = 1'b0;
`ifdef HALF_MATCH_FLAG_EN
      match_d  = {(data_d[31:16] == 16'h0001), (data_d[15:0] == 16'h0001)};
`endif
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q     <= '0;
      lo_vld_q <= 1'b0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef HALF_MATCH_FLAG_EN
      match_q  <= '0;
`endif
    end else begin
      lo_q     <= lo_d;
      lo_vld_q <= lo_vld_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
`ifdef HALF_MATCH_FLAG_EN
      match_q  <= match_d;
`endif
    end
  end

  assign dout_data  = data_q;
  assign dout_vld   = vld_q;
  assign word_cnt   = cnt_q;
`ifdef HALF_MATCH_FLAG_EN
  assign dout_match = match_q;
`endif

endmodule

// File: tb/tb_half_word_assembler.sv
// Self-checking bench for half_word_assembler: directed cases with literal expectations plus a
// randomized phase, all cross-checked every cycle against a queue-based word model.
module tb_half_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din_data = '0;
  logic        din_last = 1'b0;
  logic        din_vld = 1'b0;
  logic        din_rd;
  logic [31:0] dout_data;
  logic        dout_vld;
  logic        dout_rd = 1'b0;
  logic [15:0] word_cnt;
`ifdef HALF_MATCH_FLAG_EN
  logic [1:0]  dout_match;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  half_word_assembler #(
    .CNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_data  (din_data),
    .din_last  (din_last),
    .din_vld   (din_vld),
    .din_rd    (din_rd),
    .dout_data (dout_data),
    .dout_vld  (dout_vld),
    .dout_rd   (dout_rd),
`ifdef HALF_MATCH_FLAG_EN
    .dout_match(dout_match),
`endif
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a pending low half plus a queue of words awaiting the output handshake.
  logic [31:0] m_words[$];
  int          m_lo = -1;      // -1 means no low half held
  logic [15:0] m_cnt = '0;

  function automatic logic m_rd();
    return (m_words.size() == 0) || dout_rd || ((m_lo < 0) && !din_last);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_words.delete();
      m_lo  = -1;
      m_cnt = '0;
    end else begin
      logic acc;
      acc = din_vld && m_rd();
      if (m_words.size() != 0 && dout_rd) begin
        void'(m_words.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (acc) begin
        if (m_lo >= 0) begin
          m_words.push_back({din_data, m_lo[15:0]});
          m_lo = -1;
        end else if (din_last) begin
          m_words.push_back({16'h0000, din_data});
        end else begin
          m_lo = int'(din_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("din_rd", 32'(din_rd), 32'(m_rd()));
      chk("dout_vld", 32'(dout_vld), 32'(m_words.size() != 0));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      if (m_words.size() != 0) begin
        chk("dout_data", dout_data, m_words[0]);
`ifdef HALF_MATCH_FLAG_EN
        chk("dout_match", 32'(dout_match),
            32'({m_words[0][31:16] == 16'h0001, m_words[0][15:0] == 16'h0001}));
`endif
      end
    end
  end

  task automatic set_in(input logic [15:0] d, input logic l, input logic v, input logic r);
    din_data = d;
    din_last = l;
    din_vld  = v;
    dout_rd  = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    // Reset state
    set_in(16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_cnt", 32'(word_cnt), 32'h0);
    chk("rst_data", dout_data, 32'h0);
    chk("rst_din_rd", 32'(din_rd), 32'h1);
    rst_n = 1'b1;

    // Two 0x0001 halves; first edge out of reset accepts
    set_in(16'h0001, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(16'h0001, 1'b0, 1'b1, 1'b1);
    tick();
    chk("pair_data", dout_data, 32'h0001_0001);
    chk("pair_vld", 32'(dout_vld), 32'h1);
    chk("pair_cnt0", 32'(word_cnt), 32'h0);
`ifdef HALF_MATCH_FLAG_EN
    chk("pair_match", 32'(dout_match), 32'h3);
`endif
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pair_cnt1", 32'(word_cnt), 32'h1);
    chk("pair_vld_clr", 32'(dout_vld), 32'h0);

    // Single last beat
    set_in(16'hBEEF, 1'b1, 1'b1, 1'b1);
    tick();
    chk("single_data", dout_data, 32'h0000_BEEF);
    chk("single_vld", 32'(dout_vld), 32'h1);
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("single_cnt", 32'(word_cnt), 32'h2);

    // Backpressure: low half still accepted, high half held until dout_rd
    set_in(16'h1111, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(16'h1234, 1'b0, 1'b1, 1'b0);
    #1 chk("bp_lo_rd", 32'(din_rd), 32'h1);
    tick();
    set_in(16'h5678, 1'b0, 1'b1, 1'b0);
    #1 chk("bp_hi_rd", 32'(din_rd), 32'h0);
    tick();
    tick();
    chk("bp_stable", dout_data, 32'h0000_1111);
    set_in(16'h5678, 1'b0, 1'b1, 1'b1);
    #1 chk("bp_release_rd", 32'(din_rd), 32'h1);
    tick();
    chk("bp_data", dout_data, 32'h5678_1234);
    chk("bp_vld", 32'(dout_vld), 32'h1);
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_cnt", 32'(word_cnt), 32'h4);

    // Continuous pairs: four words in eight beat cycles
    for (int i = 0; i < 4; i++) begin
      set_in(16'(16'hA000 + i), 1'b0, 1'b1, 1'b1);
      tick();
      set_in(16'(16'hB000 + i), 1'b0, 1'b1, 1'b1);
      tick();
      chk("stream_data", dout_data, {16'(16'hB000 + i), 16'(16'hA000 + i)});
    end
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stream_cnt", 32'(word_cnt), 32'h8);

    // Back-to-back single-beat words keep dout_vld high
    for (int i = 0; i < 4; i++) begin
      set_in(16'(16'hC000 + i), 1'b1, 1'b1, 1'b1);
      tick();
      chk("b2b_vld", 32'(dout_vld), 32'h1);
      chk("b2b_data", dout_data, {16'h0000, 16'(16'hC000 + i)});
    end
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("b2b_cnt", 32'(word_cnt), 32'd12);

    // Drive the counter to all-ones, then one more handshake wraps it
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      set_in(16'($urandom), 1'b1, 1'b1, 1'b1);
      tick();
      guard++;
    end
    chk("wrap_reached", 32'(word_cnt), 32'h0000_FFFF);
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("wrap_cnt", 32'(word_cnt), 32'h0);

    // Reset mid-word discards the held low half
    set_in(16'hAAAA, 1'b0, 1'b1, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(dout_vld), 32'h0);
    chk("midrst_cnt", 32'(word_cnt), 32'h0);
    chk("midrst_rd", 32'(din_rd), 32'h1);
    tick();
    rst_n = 1'b1;
    set_in(16'h0002, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(16'h0003, 1'b0, 1'b1, 1'b1);
    tick();
    chk("postrst_data", dout_data, 32'h0003_0002);

    // Randomized traffic checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      set_in(16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) != 0));
      tick();
    end
    set_in(16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
